// File: rtl/sha256_message_build.sv
// SHA-256 message padder: forwards message blocks, then appends the 1 bit, zero fill
// and 64-bit length, adding an extra block when the length field does not fit.
module sha256_message_build (
  input  logic         clk,
  input  logic         nrst,
  input  logic         en,
  input  logic         sync_rst,
  input  logic [511:0] data_in,
  input  logic         data_in_last,
  input  logic         data_in_valid,
  output logic         data_in_ready,
  input  logic [63:0]  cfg_size,
  input  logic [1:0]   cfg_scheme,
  input  logic         cfg_last,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  output logic [511:0] data_out,
  output logic         data_out_last,
  output logic         data_out_valid,
  input  logic         data_out_ready
);
  localparam logic [1:0]   ST_IDLE  = 2'd0;
  localparam logic [1:0]   ST_DATA  = 2'd1;
  localparam logic [1:0]   ST_EXTRA = 2'd2;
  localparam logic [511:0] MSB_ONE  = {1'b1, 511'd0};

  logic [1:0]   state_reg, state_next;
  logic [63:0]  size_reg, size_next;
  logic         extra_one_reg, extra_one_next;
  logic [511:0] data_out_reg, data_out_next;
  logic         last_reg, last_next;
  logic         valid_reg, valid_next;
  logic [9:0]   r;
  logic [511:0] keep_mask, pad_bit, size_field, padded;
  logic         out_free, cfg_xfer, in_xfer;
  logic         unused_cfg;

  // Only SHA-256 padding exists; the scheme and cfg_last are accepted but have no effect.
  assign unused_cfg = ^{cfg_scheme, cfg_last};

  assign out_free      = !valid_reg || data_out_ready;
  assign cfg_ready     = nrst && en && (state_reg == ST_IDLE);
  assign data_in_ready = nrst && en && (state_reg == ST_DATA) && out_free;
  assign cfg_xfer      = cfg_valid && cfg_ready;
  assign in_xfer       = data_in_valid && data_in_ready;

  assign data_out       = data_out_reg;
  assign data_out_last  = last_reg;
  assign data_out_valid = valid_reg;

  // r = number of message bits carried by the final block (512 when it is completely full).
  assign r = (size_reg[8:0] == 9'd0 && size_reg != 64'd0) ? 10'd512 : {1'b0, size_reg[8:0]};

  genvar gi;
  generate
    for (gi = 0; gi < 512; gi++) begin : g_pad
      assign keep_mask[gi] = (10'(gi) + r) >= 10'd512;
      assign pad_bit[gi]   = (10'(gi) + r) == 10'd511;
    end
  endgenerate

  assign size_field = {448'd0, size_reg};
  assign padded     = (data_in & keep_mask) | pad_bit;

  always_comb begin
    state_next     = state_reg;
    size_next      = size_reg;
    extra_one_next = extra_one_reg;
    data_out_next  = data_out_reg;
    last_next      = last_reg;
    valid_next     = valid_reg;
    if (en) begin
      if (valid_reg && data_out_ready)
        valid_next = 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (cfg_xfer) begin
            size_next  = cfg_size;
            state_next = ST_DATA;
          end
        end
        ST_DATA: begin
          if (in_xfer) begin
            valid_next = 1'b1;
            if (!data_in_last) begin
              data_out_next = data_in;
              last_next     = 1'b0;
            end else if (r <= 10'd447) begin
              data_out_next = padded | size_field;
              last_next     = 1'b1;
              state_next    = ST_IDLE;
            end else begin
              // Length does not fit; a trailing block carries it.
              data_out_next  = (r == 10'd512) ? data_in : padded;
              extra_one_next = (r == 10'd512);
              last_next      = 1'b0;
              state_next     = ST_EXTRA;
            end
          end
        end
        ST_EXTRA: begin
          if (out_free) begin
            data_out_next = (extra_one_reg ? MSB_ONE : 512'd0) | size_field;
            last_next     = 1'b1;
            valid_next    = 1'b1;
            state_next    = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg     <= ST_IDLE;
      size_reg      <= 64'd0;
      extra_one_reg <= 1'b0;
      data_out_reg  <= 512'd0;
      last_reg      <= 1'b0;
      valid_reg     <= 1'b0;
    end else if (sync_rst) begin
      state_reg     <= ST_IDLE;
      size_reg      <= 64'd0;
      extra_one_reg <= 1'b0;
      data_out_reg  <= 512'd0;
      last_reg      <= 1'b0;
      valid_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      size_reg      <= size_next;
      extra_one_reg <= extra_one_next;
      data_out_reg  <= data_out_next;
      last_reg      <= last_next;
      valid_reg     <= valid_next;
    end
  end
endmodule

// File: tb/tb_sha256_message_build.sv
// Bench for sha256_message_build: scoreboard of expected padded blocks, popped by an
// output monitor, plus directed checks of reset, stall, enable and sync clear behaviour.
module tb_sha256_message_build;
  logic         clk = 1'b0;
  logic         nrst, en, sync_rst;
  logic [511:0] data_in;
  logic         data_in_last, data_in_valid, data_in_ready;
  logic [63:0]  cfg_size;
  logic [1:0]   cfg_scheme;
  logic         cfg_last, cfg_valid, cfg_ready;
  logic [511:0] data_out;
  logic         data_out_last, data_out_valid, data_out_ready;

  typedef struct packed {
    logic [511:0] d;
    logic         l;
  } exp_t;

  exp_t         sb[$];
  logic [511:0] msg[4];
  int           checks = 0;
  int           errors = 0;
  logic         stall = 1'b0;
  logic         rand_ready = 1'b0;

  sha256_message_build dut (
    .clk(clk), .nrst(nrst), .en(en), .sync_rst(sync_rst),
    .data_in(data_in), .data_in_last(data_in_last), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .cfg_size(cfg_size), .cfg_scheme(cfg_scheme), .cfg_last(cfg_last),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .data_out(data_out), .data_out_last(data_out_last), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_block(input logic [511:0] dv, input logic lv);
    exp_t e;
    e.d = dv;
    e.l = lv;
    sb.push_back(e);
  endtask

  // Reference padding: keep the first rem bits, append a 1, zero fill, length in the tail.
  task automatic model_message(input logic [63:0] size, input int nb);
    int rem;
    logic [511:0] blk, ext;
    rem = int'(size[8:0]);
    if (size != 64'd0 && rem == 0) rem = 512;
    for (int b = 0; b < nb - 1; b++) expect_block(msg[b], 1'b0);
    blk = msg[nb-1];
    for (int k = 0; k < 512; k++) if (k >= rem) blk[511-k] = 1'b0;
    if (rem < 512) blk[511-rem] = 1'b1;
    if (rem <= 447) begin
      blk[63:0] = size;
      expect_block(blk, 1'b1);
    end else begin
      expect_block(blk, 1'b0);
      ext = '0;
      if (rem == 512) ext[511] = 1'b1;
      ext[63:0] = size;
      expect_block(ext, 1'b1);
    end
  endtask

  task automatic send_cfg(input logic [63:0] size);
    @(negedge clk);
    cfg_size  = size;
    cfg_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (cfg_ready) begin
        @(negedge clk);
        cfg_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check_value("cfg_timeout", {511'd0, cfg_ready}, 512'd1);
    cfg_valid = 1'b0;
  endtask

  task automatic send_block(input logic [511:0] d, input logic l);
    @(negedge clk);
    data_in       = d;
    data_in_last  = l;
    data_in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (data_in_ready) begin
        @(negedge clk);
        data_in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check_value("data_timeout", {511'd0, data_in_ready}, 512'd1);
    data_in_valid = 1'b0;
  endtask

  function automatic int num_blocks(input logic [63:0] size);
    if (size == 64'd0) return 1;
    return int'((size + 64'd511) / 64'd512);
  endfunction

  task automatic drive_message(input logic [63:0] size);
    int nb;
    nb = num_blocks(size);
    send_cfg(size);
    for (int b = 0; b < nb; b++) send_block(msg[b], b == nb - 1);
  endtask

  task automatic randomize_msg();
    for (int b = 0; b < 4; b++)
      for (int w = 0; w < 16; w++) msg[b][w*32 +: 32] = $urandom;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge clk);
    check_value(tag, 512'(sb.size()), 512'd0);
  endtask

  // Output monitor: ready changes just after the rising edge, sampling happens mid-low phase.
  initial begin
    exp_t e;
    data_out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      data_out_ready = stall ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      @(negedge clk);
      #1;
      if (nrst && en && !sync_rst && data_out_valid && data_out_ready) begin
        if (sb.size() == 0) begin
          check_value("spurious_out", {511'd0, data_out_valid}, 512'd0);
        end else begin
          e = sb.pop_front();
          check_value("data_out", data_out, e.d);
          check_value("data_out_last", {511'd0, data_out_last}, {511'd0, e.l});
          $display("block out: last=%0b data=%h", data_out_last, data_out);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] sizes[8];
    nrst = 1'b0; en = 1'b1; sync_rst = 1'b0;
    data_in = '0; data_in_last = 1'b0; data_in_valid = 1'b0;
    cfg_size = '0; cfg_scheme = 2'd0; cfg_last = 1'b1; cfg_valid = 1'b0;

    #12;
    check_value("rst_data_out", data_out, 512'd0);
    check_value("rst_valid", {510'd0, data_out_valid, data_out_last}, 512'd0);
    check_value("rst_readys", {510'd0, cfg_ready, data_in_ready}, 512'd0);
    @(negedge clk);
    nrst = 1'b1;
    #1;
    check_value("post_rst_cfg_ready", {511'd0, cfg_ready}, 512'd1);
    repeat (3) @(negedge clk);
    check_value("post_rst_no_out", {511'd0, data_out_valid}, 512'd0);

    // 24-bit "abc"
    msg[0] = {24'h616263, 488'd0};
    expect_block({32'h61626380, 416'd0, 64'd24}, 1'b1);
    drive_message(64'd24);
    wait_drain("drain_abc");

    // 448 bits: length spills into an extra block
    randomize_msg();
    expect_block({msg[0][511:64], 1'b1, 63'd0}, 1'b0);
    expect_block({448'd0, 64'h1C0}, 1'b1);
    drive_message(64'd448);

    // 512 bits: full block, extra block carries the 1 bit
    randomize_msg();
    expect_block(msg[0], 1'b0);
    expect_block({1'b1, 447'd0, 64'h200}, 1'b1);
    drive_message(64'd512);

    randomize_msg();
    model_message(64'd1000, 2);
    drive_message(64'd1000);
    wait_drain("drain_directed");

    // Back-to-back messages with random output backpressure
    rand_ready = 1'b1;
    sizes = '{64'd0, 64'd1, 64'd447, 64'd511, 64'd513, 64'd960, 64'd1535, 64'd2048};
    for (int m = 0; m < 8; m++) begin
      randomize_msg();
      model_message(sizes[m], num_blocks(sizes[m]));
      drive_message(sizes[m]);
    end
    for (int m = 0; m < 6; m++) begin
      logic [63:0] sz;
      sz = 64'($urandom_range(0, 2048));
      randomize_msg();
      model_message(sz, num_blocks(sz));
      drive_message(sz);
    end
    wait_drain("drain_random");
    rand_ready = 1'b0;

    // Output stall for 5 cycles: output holds and input is refused
    stall = 1'b1;
    repeat (2) @(negedge clk);
    randomize_msg();
    model_message(64'd1000, 2);
    send_cfg(64'd1000);
    send_block(msg[0], 1'b0);
    data_in = msg[1]; data_in_last = 1'b1; data_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_value("stall_data", data_out, msg[0]);
      check_value("stall_flags", {509'd0, data_out_valid, data_out_last, data_in_ready}, 512'b100);
      @(negedge clk);
    end
    data_in_valid = 1'b0;
    stall = 1'b0;
    send_block(msg[1], 1'b1);
    wait_drain("drain_stall");

    // sync_rst discards a pending output
    stall = 1'b1;
    repeat (2) @(negedge clk);
    send_cfg(64'd1000);
    send_block(msg[0], 1'b0);
    #1;
    check_value("sync_pre_valid", {511'd0, data_out_valid}, 512'd1);
    @(negedge clk);
    sync_rst = 1'b1;
    @(negedge clk);
    sync_rst = 1'b0;
    #1;
    check_value("sync_clear", {data_out[510:0], data_out_valid}, 512'd0);
    check_value("sync_idle", {510'd0, cfg_ready, data_in_ready}, 512'b10);
    stall = 1'b0;

    // Mid-message async reset, then en=0 freezes everything
    randomize_msg();
    expect_block(msg[0], 1'b0);
    send_cfg(64'd1000);
    send_block(msg[0], 1'b0);
    wait_drain("drain_pre_reset");
    #2;
    nrst = 1'b0;
    #1;
    check_value("areset_out", data_out, 512'd0);
    check_value("areset_flags", {508'd0, data_out_valid, data_out_last, cfg_ready, data_in_ready}, 512'd0);
    @(negedge clk);
    en = 1'b0;
    nrst = 1'b1;
    cfg_size = 64'd24; cfg_valid = 1'b1;
    data_in_valid = 1'b1; data_in_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_value("en0_flags", {508'd0, data_out_valid, data_out_last, cfg_ready, data_in_ready}, 512'd0);
      @(negedge clk);
    end
    cfg_valid = 1'b0; data_in_valid = 1'b0;
    en = 1'b1;
    #1;
    check_value("en1_idle", {510'd0, cfg_ready, data_in_ready}, 512'b10);

    // Freeze in DATA: en=0 blocks the handshake until re-enabled
    msg[0] = {24'h616263, 488'd0};
    expect_block({32'h61626380, 416'd0, 64'd24}, 1'b1);
    send_cfg(64'd24);
    en = 1'b0;
    data_in = msg[0]; data_in_last = 1'b1; data_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_value("freeze_flags", {509'd0, data_out_valid, cfg_ready, data_in_ready}, 512'd0);
      @(negedge clk);
    end
    data_in_valid = 1'b0;
    en = 1'b1;
    send_block(msg[0], 1'b1);
    wait_drain("drain_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
